// File: rtl/riscv_mem_wb_stage_pkg.sv
// Shared types for the MEM->WB stage: load width encodings and the registered writeback entry.
package riscv_pkg;

    localparam int RV_XLEN       = 32;
    localparam int RV_REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_e;

    typedef struct packed {
        logic                     we;
        logic [RV_REG_ADDR_W-1:0] rd;
        logic [RV_XLEN-1:0]       data;
        logic                     misalign;
    } mem_wb_entry_t;

endpackage

// File: rtl/riscv_mem_wb_stage_if.sv
// Bus between MEM stage, the MEM->WB register stage and the register-file write port.
interface riscv_mem_wb_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN       = RV_XLEN,
    parameter int REG_ADDR_W = RV_REG_ADDR_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       read_data;
    logic                  mem_to_reg;
    logic [2:0]            load_funct3;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  load_misalign;

    modport master (
        output in_valid, alu_result, read_data, mem_to_reg, load_funct3, rd, reg_write, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, load_misalign
    );

    modport slave (
        input  in_valid, alu_result, read_data, mem_to_reg, load_funct3, rd, reg_write, wb_ready,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, load_misalign
    );

endinterface

// File: rtl/riscv_mem_wb_stage_load_align.sv
// Combinational load extraction: picks the addressed byte/half from the memory word and extends it.
module riscv_load_align
    import riscv_pkg::*;
(
    input  logic [RV_XLEN-1:0] read_data,
    input  logic [1:0]         addr,
    input  logic [2:0]         funct3,
    output logic [RV_XLEN-1:0] data,
    output logic               misalign
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = read_data[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr];
    assign half_sel = addr[1] ? read_data[31:16] : read_data[15:0];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (funct3)
            LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LBU: data = {24'b0, byte_sel};
            LH:  if (addr[0]) misalign = 1'b1; else data = {{16{half_sel[15]}}, half_sel};
            LHU: if (addr[0]) misalign = 1'b1; else data = {16'b0, half_sel};
            LW:  if (addr != 2'b00) misalign = 1'b1; else data = read_data;
            // Reserved funct3 encodings are reported through the same trap path.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_mem_wb_stage.sv
// MEM->WB register stage with 2-entry skid buffer; main entry drives the writeback port.
module riscv_mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = RV_XLEN,
    parameter int REG_ADDR_W = RV_REG_ADDR_W
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    riscv_mem_wb_stage_if.slave  bus
);

    logic [XLEN-1:0]       align_data;
    logic                  align_misalign;
    logic [XLEN-1:0]       in_data;
    logic                  in_misalign;
    logic [REG_ADDR_W-1:0] in_rd;
    mem_wb_entry_t         in_entry;

    mem_wb_entry_t main_reg, main_next;
    mem_wb_entry_t skid_reg, skid_next;
    logic          main_valid_reg, main_valid_next;
    logic          skid_valid_reg, skid_valid_next;
    logic          in_ready_reg, in_ready_next;
    logic          accept, handshake;

    riscv_load_align u_load_align (
        .read_data (bus.read_data),
        .addr      (bus.alu_result[1:0]),
        .funct3    (bus.load_funct3),
        .data      (align_data),
        .misalign  (align_misalign)
    );

    // read_data is only valid in the accept cycle, so extraction happens before registering.
    assign in_data     = bus.mem_to_reg ? align_data : bus.alu_result;
    assign in_misalign = bus.mem_to_reg & align_misalign;
    assign in_rd       = bus.rd;

    always_comb begin
        in_entry          = '0;
        in_entry.we       = bus.reg_write & (in_rd != '0) & ~in_misalign;
        in_entry.rd       = in_rd;
        in_entry.data     = in_data;
        in_entry.misalign = in_misalign;
    end

    assign accept    = bus.in_valid & in_ready_reg;
    assign handshake = main_valid_reg & bus.wb_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (handshake) begin
                if (skid_valid_reg) begin
                    main_next       = skid_reg;
                    skid_valid_next = 1'b0;
                end else begin
                    main_valid_next = 1'b0;
                end
            end
            // accept while skid is valid cannot happen: in_ready is low then.
            if (accept) begin
                if (!main_valid_reg || (handshake && !skid_valid_reg)) begin
                    main_next       = in_entry;
                    main_valid_next = 1'b1;
                end else begin
                    skid_next       = in_entry;
                    skid_valid_next = 1'b1;
                end
            end
        end
        in_ready_next = ~skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= in_ready_next;
        end
    end

    assign bus.in_ready      = in_ready_reg;
    assign bus.wb_valid      = main_valid_reg;
    assign bus.wb_we         = main_valid_reg & main_reg.we;
    assign bus.wb_rd         = main_reg.rd;
    assign bus.wb_data       = main_reg.data;
    assign bus.load_misalign = main_valid_reg & main_reg.misalign;

endmodule

// File: tb/tb_riscv_mem_wb_stage.sv
// Directed bench for riscv_mem_wb_stage: load extraction, skid ordering, flush and async reset.
module tb_riscv_mem_wb_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    riscv_mem_wb_stage_if bus ();

    riscv_mem_wb_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] rdata, input logic m2r,
                         input logic [2:0] f3, input logic [4:0] rd, input logic rw);
        bus.in_valid    = 1'b1;
        bus.alu_result  = alu;
        bus.read_data   = rdata;
        bus.mem_to_reg  = m2r;
        bus.load_funct3 = f3;
        bus.rd          = rd;
        bus.reg_write   = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] alu, input logic [31:0] rdata, input logic m2r,
                        input logic [2:0] f3, input logic [4:0] rd, input logic rw);
        drive(alu, rdata, m2r, f3, rd, rw);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic we, input logic [4:0] rd,
                           input logic [31:0] data, input logic mis);
        chk({tag, ".valid"}, {31'b0, bus.wb_valid}, {31'b0, v});
        chk({tag, ".we"}, {31'b0, bus.wb_we}, {31'b0, we});
        chk({tag, ".rd"}, {27'b0, bus.wb_rd}, {27'b0, rd});
        chk({tag, ".data"}, bus.wb_data, data);
        chk({tag, ".mis"}, {31'b0, bus.load_misalign}, {31'b0, mis});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        flush  = 1'b0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0; bus.alu_result = '0; bus.read_data = '0; bus.mem_to_reg = 1'b0;
        bus.load_funct3 = '0; bus.rd = '0; bus.reg_write = 1'b0; bus.wb_ready = 1'b1;
        #12;
        chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load extraction, one entry at a time with wb_ready=1.
        send(32'h103, 32'h80FF_1234, 1'b1, LB, 5'd5, 1'b1);
        chk_out("lb", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80, 1'b0);
        send(32'h002, 32'hBEEF_0000, 1'b1, LHU, 5'd6, 1'b1);
        chk_out("lhu", 1'b1, 1'b1, 5'd6, 32'h0000_BEEF, 1'b0);
        send(32'h006, 32'h1122_3344, 1'b1, LW, 5'd7, 1'b1);
        chk_out("lw_mis", 1'b1, 1'b0, 5'd7, 32'h0, 1'b1);
        send(32'h1234, 32'hDEAD_BEEF, 1'b0, 3'b111, 5'd0, 1'b1);
        chk_out("alu_rd0", 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0);
        send(32'h002, 32'h8001_0000, 1'b1, LH, 5'd8, 1'b1);
        chk_out("lh", 1'b1, 1'b1, 5'd8, 32'hFFFF_8001, 1'b0);
        send(32'h001, 32'h0000_A500, 1'b1, LBU, 5'd9, 1'b1);
        chk_out("lbu", 1'b1, 1'b1, 5'd9, 32'h0000_00A5, 1'b0);
        send(32'h001, 32'h0000_A500, 1'b1, LH, 5'd10, 1'b1);
        chk_out("lh_mis", 1'b1, 1'b0, 5'd10, 32'h0, 1'b1);
        send(32'h000, 32'h1234_5678, 1'b1, 3'b011, 5'd11, 1'b1);
        chk_out("illegal", 1'b1, 1'b0, 5'd11, 32'h0, 1'b1);
        send(32'h000, 32'h1234_5678, 1'b1, LW, 5'd12, 1'b1);
        chk_out("lw", 1'b1, 1'b1, 5'd12, 32'h1234_5678, 1'b0);
        tick();
        chk("idle.valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("idle.we", {31'b0, bus.wb_we}, 32'd0);

        // Backpressure: A, B fill the buffer, C waits, then drain in order.
        bus.wb_ready = 1'b0;
        send(32'hA, 32'h0, 1'b0, LB, 5'd1, 1'b1);
        chk("bp.A.ready", {31'b0, bus.in_ready}, 32'd1);
        chk("bp.A.data", bus.wb_data, 32'hA);
        send(32'hB, 32'h0, 1'b0, LB, 5'd2, 1'b1);
        chk("bp.B.ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp.B.data", bus.wb_data, 32'hA);
        drive(32'hC, 32'h0, 1'b0, LB, 5'd3, 1'b1);
        tick();
        chk("bp.C.ready", {31'b0, bus.in_ready}, 32'd0);
        chk("bp.hold.data", bus.wb_data, 32'hA);
        bus.wb_ready = 1'b1;
        tick();
        chk_out("bp.out_B", 1'b1, 1'b1, 5'd2, 32'hB, 1'b0);
        chk("bp.B.ready2", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("bp.out_C", 1'b1, 1'b1, 5'd3, 32'hC, 1'b0);
        tick();
        chk("bp.empty", {31'b0, bus.wb_valid}, 32'd0);

        // Flush a full buffer with a same-cycle input.
        bus.wb_ready = 1'b0;
        send(32'h11, 32'h0, 1'b0, LB, 5'd4, 1'b1);
        send(32'h22, 32'h0, 1'b0, LB, 5'd4, 1'b1);
        chk("fl.full", {31'b0, bus.in_ready}, 32'd0);
        drive(32'h33, 32'h0, 1'b0, LB, 5'd4, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl.valid", {31'b0, bus.wb_valid}, 32'd0);
        chk("fl.we", {31'b0, bus.wb_we}, 32'd0);
        chk("fl.ready", {31'b0, bus.in_ready}, 32'd1);
        bus.wb_ready = 1'b1;
        tick();
        chk("fl.after", {31'b0, bus.wb_valid}, 32'd0);

        // Asynchronous reset mid-stall.
        bus.wb_ready = 1'b0;
        send(32'h44, 32'h0, 1'b0, LB, 5'd7, 1'b1);
        send(32'h55, 32'h0, 1'b0, LB, 5'd7, 1'b1);
        chk("rs.pre", {31'b0, bus.wb_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rs.async", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rs.ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.wb_ready = 1'b1;
        tick();
        tick();
        chk("rs.after", {31'b0, bus.wb_valid}, 32'd0);
        chk("rs.after_we", {31'b0, bus.wb_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
